// File: rtl/load_store_unit_if.sv
// Bundle of request/response handshake and data-RAM port signals for load_store_unit.
// slave is the unit itself; master is the surrounding pipeline plus RAM.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic        mem_read_enable;
    logic [3:0]  mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_out,
        input  req_ready, resp_valid, resp_error, resp_rdata,
        input  mem_read_enable, mem_write_enable, mem_address, mem_data_in
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_out,
        output req_ready, resp_valid, resp_error, resp_rdata,
        output mem_read_enable, mem_write_enable, mem_address, mem_data_in
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator: RV32I width decode, lane strobes and
// replication, registered-read latency wait, and aligned sign/zero-extended loads.
module load_store_unit #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    localparam int unsigned CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt;
    logic          op_write;
    logic [2:0]    op_funct3;
    logic [1:0]    op_offset;

    logic          accept;
    logic          req_err;
    logic [3:0]    req_strobe;
    logic [31:0]   req_wdata_rep;
    logic [31:0]   shifted;
    logic [31:0]   load_val;

    assign bus.req_ready = (state_q == S_IDLE);

    // Request decode, evaluated on the raw request so results land on the accept edge
    always_comb begin
        accept        = bus.req_valid && (state_q == S_IDLE);
        req_err       = 1'b0;
        req_strobe    = 4'b1111;
        req_wdata_rep = bus.req_wdata;

        if (bus.req_write)
            req_err = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
        else
            req_err = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);

        if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
            req_err = 1'b1;
        if ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00))
            req_err = 1'b1;

        case (bus.req_funct3[1:0])
            2'b00: begin
                req_strobe    = 4'b0001 << bus.req_addr[1:0];
                req_wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                req_strobe    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                req_strobe    = 4'b1111;
                req_wdata_rep = bus.req_wdata;
            end
        endcase
    end

    always_comb begin
        shifted  = bus.mem_data_out >> {op_offset, 3'b000};
        load_val = bus.mem_data_out;
        case (op_funct3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_val = {24'h000000, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_val = {16'h0000, shifted[15:0]};
            default: load_val = bus.mem_data_out;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = req_err ? S_RESP : S_ACCESS;
            S_ACCESS: state_d = op_write ? S_RESP : S_WAIT;
            S_WAIT:   if (wait_cnt == '0) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the current state so strobes and resp_valid
    // appear exactly in the cycle of the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q              <= S_IDLE;
            wait_cnt             <= '0;
            op_write             <= 1'b0;
            op_funct3            <= '0;
            op_offset            <= '0;
            bus.resp_valid       <= 1'b0;
            bus.resp_error       <= 1'b0;
            bus.resp_rdata       <= '0;
            bus.mem_read_enable  <= 1'b0;
            bus.mem_write_enable <= '0;
            bus.mem_address      <= '0;
            bus.mem_data_in      <= '0;
        end else begin
            state_q              <= state_d;
            bus.resp_valid       <= 1'b0;
            bus.mem_read_enable  <= 1'b0;
            bus.mem_write_enable <= '0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_write       <= bus.req_write;
                        op_funct3      <= bus.req_funct3;
                        op_offset      <= bus.req_addr[1:0];
                        bus.resp_error <= req_err;
                        bus.resp_rdata <= '0;
                        if (req_err) begin
                            bus.resp_valid <= 1'b1;
                        end else begin
                            bus.mem_address <= {2'b00, bus.req_addr[31:2]};
                            bus.mem_data_in <= req_wdata_rep;
                            if (bus.req_write)
                                bus.mem_write_enable <= req_strobe;
                            else
                                bus.mem_read_enable <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    wait_cnt <= CW'(READ_LATENCY - 1);
                    if (op_write)
                        bus.resp_valid <= 1'b1;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        bus.resp_rdata <= load_val;
                        bus.resp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (read latency 1 and 3) with behavioural RAMs,
// checked against a byte-level reference model of RV32I load/store semantics.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if ia ();
    load_store_unit_if ib ();

    load_store_unit #(.READ_LATENCY(1)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    load_store_unit #(.READ_LATENCY(3)) dut_b (.clk(clk), .reset(reset), .bus(ib));

    logic        sel_b;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    assign ia.req_valid  = req_valid & ~sel_b;
    assign ib.req_valid  = req_valid & sel_b;
    assign ia.req_write  = req_write;
    assign ib.req_write  = req_write;
    assign ia.req_funct3 = req_funct3;
    assign ib.req_funct3 = req_funct3;
    assign ia.req_addr   = req_addr;
    assign ib.req_addr   = req_addr;
    assign ia.req_wdata  = req_wdata;
    assign ib.req_wdata  = req_wdata;

    // RAM models: A has one registered read stage, B three
    logic [31:0] ram_a [64];
    logic [31:0] ram_b [64];
    logic [31:0] rd_a;
    logic [31:0] pb0, pb1, pb2;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ia.mem_write_enable[i]) ram_a[ia.mem_address[5:0]][8*i +: 8] <= ia.mem_data_in[8*i +: 8];
            if (ib.mem_write_enable[i]) ram_b[ib.mem_address[5:0]][8*i +: 8] <= ib.mem_data_in[8*i +: 8];
        end
        if (ia.mem_read_enable) rd_a <= ram_a[ia.mem_address[5:0]];
        if (ib.mem_read_enable) pb0 <= ram_b[ib.mem_address[5:0]];
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign ia.mem_data_out = rd_a;
    assign ib.mem_data_out = pb2;

    logic        cur_ready, cur_rv, cur_err, cur_re;
    logic [3:0]  cur_we;
    logic [31:0] cur_addr, cur_din, cur_rdata;
    assign cur_ready = sel_b ? ib.req_ready        : ia.req_ready;
    assign cur_rv    = sel_b ? ib.resp_valid       : ia.resp_valid;
    assign cur_err   = sel_b ? ib.resp_error       : ia.resp_error;
    assign cur_rdata = sel_b ? ib.resp_rdata       : ia.resp_rdata;
    assign cur_re    = sel_b ? ib.mem_read_enable  : ia.mem_read_enable;
    assign cur_we    = sel_b ? ib.mem_write_enable : ia.mem_write_enable;
    assign cur_addr  = sel_b ? ib.mem_address      : ia.mem_address;
    assign cur_din   = sel_b ? ib.mem_data_in      : ia.mem_data_in;

    logic [31:0] ref_mem [2][64];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_err(input bit wr, input logic [2:0] f3, input logic [1:0] off);
        if (wr && f3 > 3'd2) return 1'b1;
        if (!wr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        return (int'(off) % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [1:0] off);
        return 4'(((32'd1 << m_size(f3)) - 32'd1) << off);
    endfunction

    function automatic logic [31:0] m_din(input logic [2:0] f3, input logic [31:0] wd);
        case (m_size(f3))
            1:       return {24'h0, wd[7:0]} * 32'h01010101;
            2:       return {16'h0, wd[15:0]} * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
        int unsigned bits;
        logic [31:0] v, m;
        v = word >> (8 * off);
        if (m_size(f3) < 4) begin
            bits = 8 * m_size(f3);
            m = (32'd1 << bits) - 32'd1;
            v = v & m;
            if (!f3[2] && v[bits-1]) v = v | ~m;
        end
        return v;
    endfunction

    task automatic txn(input bit b, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit hold, output logic [31:0] got);
        bit err;
        int unsigned lat;
        logic [1:0] off;
        logic [5:0] idx;
        logic [3:0] mask;
        logic [31:0] din, exp_rd;
        off    = addr[1:0];
        idx    = addr[7:2];
        err    = m_err(wr, f3, off);
        lat    = err ? 1 : (wr ? 2 : (b ? 5 : 3));
        mask   = m_mask(f3, off);
        din    = m_din(f3, wd);
        exp_rd = (err || wr) ? 32'h0 : m_load(ref_mem[b][idx], f3, off);
        got    = '0;
        @(negedge clk);
        sel_b = b;
        #1;
        check($sformatf("req_ready idle a=%h", addr), {31'h0, cur_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        for (int unsigned n = 1; n <= lat; n++) begin
            @(negedge clk);
            if (!hold) begin
                req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
            check($sformatf("req_ready busy a=%h n=%0d", addr, n), {31'h0, cur_ready}, 32'd0);
            check($sformatf("resp_valid a=%h n=%0d", addr, n), {31'h0, cur_rv}, {31'h0, n == lat});
            if (n == 1 && !err) begin
                check($sformatf("mem_address a=%h", addr), cur_addr, {2'b00, addr[31:2]});
                check($sformatf("write_enable a=%h f3=%0d", addr, f3), {28'h0, cur_we}, wr ? {28'h0, mask} : 32'h0);
                check($sformatf("read_enable a=%h", addr), {31'h0, cur_re}, {31'h0, !wr});
                if (wr) check($sformatf("mem_data_in a=%h", addr), cur_din, din);
            end else begin
                check($sformatf("no write strobe a=%h n=%0d", addr, n), {28'h0, cur_we}, 32'h0);
                check($sformatf("no read strobe a=%h n=%0d", addr, n), {31'h0, cur_re}, 32'h0);
            end
            if (n == lat) begin
                check($sformatf("resp_error a=%h f3=%0d", addr, f3), {31'h0, cur_err}, {31'h0, err});
                check($sformatf("resp_rdata a=%h f3=%0d", addr, f3), cur_rdata, exp_rd);
                got = cur_rdata;
            end
        end
        if (wr && !err)
            for (int i = 0; i < 4; i++)
                if (mask[i]) ref_mem[b][idx][8*i +: 8] = din[8*i +: 8];
    endtask

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    initial begin
        logic [31:0] g;
        sel_b = 1'b0; reset = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = F_W; req_addr = 32'h0; req_wdata = 32'h1234;
        repeat (3) @(negedge clk);
        check("reset resp_valid", {31'h0, ia.resp_valid}, 32'h0);
        check("reset resp_error", {31'h0, ia.resp_error}, 32'h0);
        check("reset resp_rdata", ia.resp_rdata, 32'h0);
        check("reset read_enable", {31'h0, ia.mem_read_enable}, 32'h0);
        check("reset write_enable", {28'h0, ia.mem_write_enable}, 32'h0);
        check("reset mem_address", ia.mem_address, 32'h0);
        check("reset mem_data_in", ia.mem_data_in, 32'h0);
        check("reset b write_enable", {28'h0, ib.mem_write_enable}, 32'h0);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("ready after reset", {31'h0, ia.req_ready}, 32'd1);

        for (int unsigned i = 0; i < 64; i++) txn(1'b0, 1'b1, F_W, i * 4, $urandom, 1'b0, g);
        for (int unsigned i = 0; i < 16; i++) txn(1'b1, 1'b1, F_W, i * 4, $urandom, 1'b0, g);

        txn(1'b0, 1'b1, F_W, 32'h10, 32'hDEADBEEF, 1'b0, g);
        txn(1'b0, 1'b0, F_W, 32'h10, 32'h0, 1'b0, g);
        check("lw deadbeef", g, 32'hDEADBEEF);
        txn(1'b0, 1'b1, F_B, 32'h13, 32'h000000A5, 1'b0, g);
        txn(1'b0, 1'b1, F_W, 32'h10, 32'h80FF7F01, 1'b0, g);
        txn(1'b0, 1'b0, F_B, 32'h12, 32'h0, 1'b0, g);  check("lb 0x12", g, 32'hFFFFFFFF);
        txn(1'b0, 1'b0, F_BU, 32'h12, 32'h0, 1'b0, g); check("lbu 0x12", g, 32'h000000FF);
        txn(1'b0, 1'b0, F_H, 32'h12, 32'h0, 1'b0, g);  check("lh 0x12", g, 32'hFFFF80FF);
        txn(1'b0, 1'b0, F_HU, 32'h10, 32'h0, 1'b0, g); check("lhu 0x10", g, 32'h00007F01);
        txn(1'b0, 1'b0, F_W, 32'h06, 32'h0, 1'b0, g);
        txn(1'b0, 1'b1, F_H, 32'h03, 32'h1234, 1'b0, g);
        txn(1'b0, 1'b0, 3'b011, 32'h10, 32'h0, 1'b0, g);

        for (int i = 0; i < 200; i++)
            txn(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0, g);

        // Latency-3 instance: held request must be taken only after RESP
        txn(1'b1, 1'b1, F_W, 32'h20, 32'hCAFEF00D, 1'b0, g);
        txn(1'b1, 1'b0, F_W, 32'h20, 32'h0, 1'b1, g);
        txn(1'b1, 1'b0, F_W, 32'h20, 32'h0, 1'b0, g);
        check("lw b cafef00d", g, 32'hCAFEF00D);

        @(negedge clk);
        sel_b = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_funct3 = F_W; req_addr = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort resp_valid", {31'h0, cur_rv}, 32'h0);
        check("abort read_enable", {31'h0, cur_re}, 32'h0);
        check("abort write_enable", {28'h0, cur_we}, 32'h0);
        check("abort mem_address", cur_addr, 32'h0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort ready", {31'h0, cur_ready}, 32'd1);
            check("abort no resp", {31'h0, cur_rv}, 32'h0);
        end
        txn(1'b1, 1'b0, F_W, 32'h20, 32'h0, 1'b0, g);
        check("lw b after abort", g, 32'hCAFEF00D);

        for (int i = 0; i < 30; i++)
            txn(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom} & 32'h0000_003F, $urandom, 1'b0, g);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
